regfile_flags: RTL

REGFILE_FLAGS -- requirements
Module: regfile_flags

---
 rtl/regfile_flags.sv | 121 ++++++++++++
 1 files changed

// File: rtl/regfile_flags.sv
// 16x16 register file (R0 hardwired to zero, two combinational read ports
// with write bypass) plus a 3-bit ALU flag register gated by opcode class.

module regfile_flags_cell #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_we,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_q <= '0;
    else if (i_we) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

module regfile_flags (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  src_reg1,
  input  logic [3:0]  src_reg2,
  input  logic [3:0]  dst_reg,
  input  logic        write_reg,
  input  logic [15:0] dst_data,
  output logic [15:0] src_data1,
  output logic [15:0] src_data2,
  input  logic [3:0]  opcode,
  input  logic [2:0]  alu_flags,
  input  logic        flag_en,
  output logic [2:0]  flags
);
  localparam int NREG = 16;
  localparam int W    = 16;
  localparam int NRD  = 2;

  typedef struct packed {
    logic         en;
    logic [3:0]   addr;
    logic [W-1:0] data;
  } wr_req_t;

  typedef enum logic [1:0] {FL_HOLD, FL_ALL, FL_Z} fl_cls_e;

  wr_req_t                     w_wr;
  logic [NREG-1:0][W-1:0]      w_rf;
  logic [NRD-1:0][3:0]         w_rd_addr;
  logic [NRD-1:0][W-1:0]       w_rd_data;
  fl_cls_e                     w_fl_cls;
  logic [2:0]                  w_flags_nxt;
  logic [2:0]                  r_flags;

  // A write to R0 is dropped here, so neither storage nor bypass ever sees it.
  assign w_wr.en   = write_reg && (dst_reg != 4'd0);
  assign w_wr.addr = dst_reg;
  assign w_wr.data = dst_data;

  genvar g;
  generate
    for (g = 0; g < NREG; g++) begin : g_reg
      if (g == 0) begin : g_zero
        assign w_rf[g] = '0;
      end else begin : g_cell
        regfile_flags_cell #(.W(W)) u_cell (
          .clk   (clk),
          .rst_n (rst_n),
          .i_we  (w_wr.en && (w_wr.addr == 4'(g))),
          .i_d   (w_wr.data),
          .o_q   (w_rf[g])
        );
      end
    end
  endgenerate

  assign w_rd_addr[0] = src_reg1;
  assign w_rd_addr[1] = src_reg2;

  // Reads are forced to zero while reset is held, including the bypass path.
  generate
    for (g = 0; g < NRD; g++) begin : g_rd
      always_comb begin
        w_rd_data[g] = w_rf[w_rd_addr[g]];
        if (w_wr.en && (w_wr.addr == w_rd_addr[g])) w_rd_data[g] = w_wr.data;
        if (!rst_n) w_rd_data[g] = '0;
      end
    end
  endgenerate

  assign src_data1 = w_rd_data[0];
  assign src_data2 = w_rd_data[1];

  always_comb begin
    w_fl_cls = FL_HOLD;
    case (opcode)
      4'b0000, 4'b0001:                   w_fl_cls = FL_ALL;
      4'b0010, 4'b0100, 4'b0101, 4'b0110: w_fl_cls = FL_Z;
      default:                            w_fl_cls = FL_HOLD;
    endcase
  end

  always_comb begin
    w_flags_nxt = r_flags;
    case (w_fl_cls)
      FL_ALL:  w_flags_nxt = alu_flags;
      FL_Z:    w_flags_nxt = {alu_flags[2], r_flags[1:0]};
      default: w_flags_nxt = r_flags;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_flags <= 3'b000;
    else if (flag_en) r_flags <= w_flags_nxt;
  end

  assign flags = r_flags;
endmodule
